// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the 64-bit ALU: ALU-control decode, write-back bypass,
// stall/flush handling and optional output-side operand forwarding (macro FORWARD_EN).
module id_ex_stage #(
  parameter int unsigned W  = 64,
  parameter int unsigned RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [W-1:0]  id_rdata1,
  input  logic [W-1:0]  id_rdata2,
  input  logic [W-1:0]  id_imm,
  input  logic [RW-1:0] id_rn,
  input  logic [RW-1:0] id_rm,
  input  logic [RW-1:0] id_rd,
  input  logic [1:0]    id_aluop,
  input  logic [10:0]   id_opcode,
  input  logic          id_alusrc,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          id_memwrite,
  input  logic          id_branch,
  input  logic          exmem_regwrite,
  input  logic [RW-1:0] exmem_rd,
  input  logic [W-1:0]  exmem_result,
  input  logic          memwb_regwrite,
  input  logic [RW-1:0] memwb_rd,
  input  logic [W-1:0]  memwb_result,
  output logic          ex_valid,
  output logic [W-1:0]  ex_input1,
  output logic [W-1:0]  ex_input2,
  output logic [3:0]    ex_aluopt,
  output logic [W-1:0]  ex_store_data,
  output logic [RW-1:0] ex_rd,
  output logic          ex_regwrite,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic          ex_branch,
  output logic          ex_illegal
);

  localparam logic [RW-1:0] XZR    = RW'(31);
  localparam logic [10:0]   OP_ADD = 11'b10001011000;
  localparam logic [10:0]   OP_SUB = 11'b11001011000;
  localparam logic [10:0]   OP_AND = 11'b10001010000;
  localparam logic [10:0]   OP_ORR = 11'b10101010000;

  typedef struct packed {
    logic          valid;
    logic [W-1:0]  rdata1;
    logic [W-1:0]  rdata2;
    logic [W-1:0]  imm;
    logic [RW-1:0] rn;
    logic [RW-1:0] rm;
    logic [RW-1:0] rd;
    logic [3:0]    aluopt;
    logic          alusrc;
    logic          regwrite;
    logic          memread;
    logic          memwrite;
    logic          branch;
    logic          illegal;
  } stage_t;

  stage_t     stage_q, stage_d;
  logic [3:0] aluopt_dec;
  logic       illegal_dec;
  logic       byp_rn, byp_rm;
  logic       ctl_ok;

  // ALU control: main-decoder ALUOp refined by the R-type opcode
  always_comb begin
    aluopt_dec  = 4'b0001;
    illegal_dec = 1'b0;
    unique case (id_aluop)
      2'b00: aluopt_dec = 4'b0010;
      2'b01: aluopt_dec = 4'b0111;
      2'b10: begin
        unique case (id_opcode)
          OP_ADD:  aluopt_dec = 4'b0010;
          OP_SUB:  aluopt_dec = 4'b0110;
          OP_AND:  aluopt_dec = 4'b0000;
          OP_ORR:  aluopt_dec = 4'b0001;
          default: illegal_dec = 1'b1;
        endcase
      end
      default: illegal_dec = 1'b1;
    endcase
  end

  // Write-back bypass covers the register-file write/read collision in the same cycle
  always_comb begin
    byp_rn = memwb_regwrite && (memwb_rd == id_rn) && (id_rn != XZR);
    byp_rm = memwb_regwrite && (memwb_rd == id_rm) && (id_rm != XZR);
    ctl_ok = id_valid && !illegal_dec;
  end

  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = '0;
    end else if (!stall) begin
      stage_d.valid    = id_valid;
      stage_d.rdata1   = byp_rn ? memwb_result : id_rdata1;
      stage_d.rdata2   = byp_rm ? memwb_result : id_rdata2;
      stage_d.imm      = id_imm;
      stage_d.rn       = id_rn;
      stage_d.rm       = id_rm;
      stage_d.rd       = id_rd;
      stage_d.aluopt   = id_valid ? aluopt_dec : 4'b0000;
      stage_d.alusrc   = id_valid & id_alusrc;
      stage_d.regwrite = ctl_ok & id_regwrite;
      stage_d.memread  = ctl_ok & id_memread;
      stage_d.memwrite = ctl_ok & id_memwrite;
      stage_d.branch   = id_valid & id_branch;
      stage_d.illegal  = id_valid & illegal_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stage_q <= '0;
    else     stage_q <= stage_d;
  end

  logic [W-1:0] fwd_rn, fwd_rm;

`ifdef FORWARD_EN
  // EX/MEM is the younger result, so it wins over MEM/WB
  always_comb begin
    fwd_rn = stage_q.rdata1;
    if (exmem_regwrite && (exmem_rd == stage_q.rn) && (stage_q.rn != XZR))
      fwd_rn = exmem_result;
    else if (memwb_regwrite && (memwb_rd == stage_q.rn) && (stage_q.rn != XZR))
      fwd_rn = memwb_result;

    fwd_rm = stage_q.rdata2;
    if (exmem_regwrite && (exmem_rd == stage_q.rm) && (stage_q.rm != XZR))
      fwd_rm = exmem_result;
    else if (memwb_regwrite && (memwb_rd == stage_q.rm) && (stage_q.rm != XZR))
      fwd_rm = memwb_result;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{exmem_regwrite, exmem_rd, exmem_result, stage_q.rn, stage_q.rm};

  always_comb begin
    fwd_rn = stage_q.rdata1;
    fwd_rm = stage_q.rdata2;
  end
`endif

  assign ex_valid      = stage_q.valid;
  assign ex_input2     = fwd_rn;
  assign ex_input1     = stage_q.alusrc ? stage_q.imm : fwd_rm;
  assign ex_store_data = fwd_rm;
  assign ex_aluopt     = stage_q.aluopt;
  assign ex_rd         = stage_q.rd;
  assign ex_regwrite   = stage_q.regwrite;
  assign ex_memread    = stage_q.memread;
  assign ex_memwrite   = stage_q.memwrite;
  assign ex_branch     = stage_q.branch;
  assign ex_illegal    = stage_q.illegal;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage directly upstream of the 64-bit ALU.
- Latches decoded operands, immediate, destination register and control bits from decode.
- Translates the 2-bit main-decoder ALUOp plus the 11-bit R-type opcode into the ALU's 4-bit operation select.
- Forwards EX/MEM and MEM/WB results onto the ALU operand lines.
- Supports pipeline stall and flush (bubble insertion).

## Interface
Parameters:
- W, 64, datapath width
- RW, 5, register index width

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold all stage registers
- flush  in  1  load a bubble
- id_valid  in  1  decode slot holds an instruction
- id_rdata1, id_rdata2  in  W  register-file read ports (Rn, Rm)
- id_imm  in  W  sign-extended immediate
- id_rn, id_rm, id_rd  in  RW  register indices
- id_aluop  in  2  00 mem/add, 01 CBZ, 10 R-type, 11 reserved
- id_opcode  in  11  R-type opcode field
- id_alusrc  in  1  1 = immediate replaces Rm operand
- id_regwrite, id_memread, id_memwrite, id_branch  in  1  control bits
- exmem_regwrite  in  1;  exmem_rd  in  RW;  exmem_result  in  W  (EX/MEM forwarding source)
- memwb_regwrite  in  1;  memwb_rd  in  RW;  memwb_result  in  W  (MEM/WB forwarding source)
- ex_valid  out  1  stage holds a live instruction
- ex_input1  out  W  ALU input1 (Rm or immediate)
- ex_input2  out  W  ALU input2 (Rn)
- ex_aluopt  out  4  ALU operation select
- ex_store_data  out  W  forwarded Rm value for stores
- ex_rd  out  RW;  ex_regwrite, ex_memread, ex_memwrite, ex_branch  out  1
- ex_illegal  out  1  undecodable ALU operation

## Operation
Operand placement:
- input2 = Rn, input1 = Rm/immediate. The ALU computes SUB as input2 − input1, which gives Rn − Rm.
- For CBZ, decode routes Rt onto id_rn/id_rdata1; the ALU's pass-input2 operation then tests Rt.

ALU control decode (at capture):
- aluop 00 → 0010
- aluop 01 → 0111
- aluop 10 with opcode 10001011000 (ADD) → 0010
- aluop 10 with opcode 11001011000 (SUB) → 0110
- aluop 10 with opcode 10001010000 (AND) → 0000
- aluop 10 with opcode 10101010000 (ORR) → 0001
- Any other aluop 10 opcode, or aluop 11 → 0001, ex_illegal = 1; latched regwrite, memwrite and memread forced to 0.

Write-back bypass (at capture, always present):
- If memwb_regwrite && memwb_rd == id_rn && id_rn != 31, latch memwb_result instead of id_rdata1.
- The same rule applies to id_rm / id_rdata2.

Register update priority, per rising edge:
1. rst: all stage registers cleared to 0.
2. flush: bubble loaded (all registers 0). Flush overrides stall.
3. stall: all registers hold.
4. Otherwise: capture the id_* inputs. ex_valid = id_valid. When id_valid = 0, control bits are captured as 0.

Forwarding, combinational on the output side from latched Rn/Rm indices:
- EX/MEM match (exmem_regwrite, exmem_rd == index, index != 31) has priority over MEM/WB match.
- With no match, the latched register value is used.
- ex_input2 = fwd(Rn).
- ex_store_data = fwd(Rm).
- ex_input1 = imm if alusrc else fwd(Rm). The immediate is never forwarded.
- Register 31 (XZR) is never forwarded or bypassed.

## Timing
- Latency: one cycle from id_* to the ex_* register outputs.
- Forwarding adds a combinational path from exmem_*/memwb_* to ex_input1, ex_input2 and ex_store_data, with no extra cycle.
- Reset value of every output is 0. ex_aluopt resets to 0000; the ALU therefore computes AND of zeros and asserts its zero flag.
- stall held for N cycles: outputs unchanged for N cycles, except that forwarded operands follow changes on exmem_*/memwb_*.
- rst asserted mid-stall: wins immediately; the next cycle shows the bubble state.

## Configuration
- FORWARD_EN defined: output-side EX/MEM and MEM/WB forwarding as described.
- FORWARD_EN undefined:
  - ex_input1, ex_input2 and ex_store_data come straight from the latched values.
  - exmem_* inputs are unused; memwb_* inputs are used only by the capture-time write-back bypass.
  - Hazard avoidance is then the responsibility of upstream stall logic.

## Test plan
- Reset → all ex_* = 0; release rst with id_valid = 0 for 3 cycles → outputs stay 0.
- R-type SUB (aluop 10, opcode 11001011000, rdata1 = 10, rdata2 = 3) → next cycle ex_aluopt = 0110, ex_input2 = 10, ex_input1 = 3, ex_valid = 1.
- Forward priority (FORWARD_EN): latched Rn = 4; exmem_rd = 4 with result 0xAA; memwb_rd = 4 with result 0xBB; both regwrite = 1 → ex_input2 = 0xAA; deassert exmem_regwrite → 0xBB; Rn = 31 → latched value.
- Capture bypass: id_rn = 7, id_rdata1 = 1, memwb_rd = 7, memwb_result = 99, memwb_regwrite = 1 → ex_input2 = 99 (also without FORWARD_EN).
- Stall 2 cycles with a new instruction pending → outputs hold; stall and flush together → bubble (ex_valid = 0, ex_regwrite = 0).
- Illegal opcode 11111111111 with aluop 10 and regwrite = 1 → ex_illegal = 1, ex_aluopt = 0001, ex_regwrite = 0; aluop 01 → ex_aluopt = 0111.
